dmem_mmio: RTL and testbench

- Data-memory block for the 5-stage pipeline; consumes the MEM-stage outputs (ALU result as address, store data, MemWrite) and produces the load word registered into MEM/WB.
- Contains word-addressed RAM, a free-running cycle counter and a debug output FIFO with valid/ready drain, all memory-mapped.
- Reads are combinational, because the pipeline has no stall. Writes are synchronous.

---
 rtl/dmem_mmio_if.sv | 23 ++
 rtl/dmem_mmio.sv | 113 +++++++++++
 tb/tb_dmem_mmio.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dmem_mmio_if.sv
// MEM-stage data bus plus debug FIFO drain, shared by the data-memory block and its driver.
// Latency: none of its own; pure wiring between the pipeline and dmem_mmio.
// Backpressure: out_ready from the consumer gates FIFO pops; the pipeline side never stalls.
interface dmem_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        err;

  modport master (
    output addr, wdata, we, out_ready,
    input  rdata, out_data, out_valid, err
  );

  modport slave (
    input  addr, wdata, we, out_ready,
    output rdata, out_data, out_valid, err
  );
endinterface

// File: rtl/dmem_mmio.sv
// Data memory with memory-mapped CYCLE counter, OUT FIFO and STATUS; DMEM_ERR_EN adds sticky err.
// Latency: loads combinational (0 cycles); stores and FIFO pushes visible on the next cycle.
// Backpressure: out_ready drains the FIFO; a push to a full FIFO without a pop is dropped and flagged.
module dmem_mmio #(
  parameter int RAM_AW     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        NReset,
  dmem_mmio_if.slave bus
);
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

  // Address decode: word-aligned, low two address bits are don't-care.
  logic [RAM_AW-1:0] ramIdx;
  logic              isRam;
  logic              isCycle;
  logic              isOut;
  logic              isStatus;
  logic              unusedAddrBits;

  assign ramIdx         = bus.addr[RAM_AW+1:2];
  assign isRam          = (bus.addr[31:RAM_AW+2] == '0);
  assign isCycle        = (bus.addr[31:2] == 30'h2000_0000);
  assign isOut          = (bus.addr[31:2] == 30'h2000_0001);
  assign isStatus       = (bus.addr[31:2] == 30'h2000_0002);
  assign unusedAddrBits = ^bus.addr[1:0];

  logic [31:0] mem [2**RAM_AW];
  logic [31:0] cycleCnt;

  logic [31:0]   fifoMem [FIFO_DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [PW:0]   count;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          doPush;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign push   = bus.we & isOut;
  assign pop    = ~empty & bus.out_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign doPush = push & (~full | pop);

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (bus.we && isRam) mem[ramIdx] <= bus.wdata;
  end

  // Free-running cycle counter; a store overrides the increment.
  always_ff @(posedge clk or negedge NReset) begin
    if (!NReset)                cycleCnt <= '0;
    else if (bus.we && isCycle) cycleCnt <= bus.wdata;
    else                        cycleCnt <= cycleCnt + 32'd1;
  end

  // FIFO storage has no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (doPush) fifoMem[wrPtr] <= bus.wdata;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge NReset) begin
    if (!NReset) begin
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (pop)    rdPtr <= rdPtr + 1'b1;
      case ({doPush, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop)                     overflow <= 1'b1;
      else if (bus.we && isStatus && bus.wdata[2]) overflow <= 1'b0;
    end
  end

  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? 32'd0 : fifoMem[rdPtr];

  // Side-effect-free read mux; unmapped addresses read as zero.
  always_comb begin
    bus.rdata = 32'd0;
    if (isRam)         bus.rdata = mem[ramIdx];
    else if (isCycle)  bus.rdata = cycleCnt;
    else if (isOut)    bus.rdata = 32'(count);
    else if (isStatus) bus.rdata = {29'd0, overflow, empty, full};
  end

`ifdef DMEM_ERR_EN
  logic errReg;

  // Any cycle presenting an unmapped address latches the error until reset.
  always_ff @(posedge clk or negedge NReset) begin
    if (!NReset)                                    errReg <= 1'b0;
    else if (!(isRam | isCycle | isOut | isStatus)) errReg <= 1'b1;
  end

  assign bus.err = errReg;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: vector table plus FIFO scoreboard and hand-written corner cases.
// Latency: inputs driven at negedge, outputs sampled 1ns later, state commits at the next posedge.
// Backpressure: out_ready is driven per vector; the scoreboard models drops on a full FIFO.
module tb_dmem_mmio;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_OUT    = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam int          DEPTH    = 4;

`ifdef DMEM_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        rdy;
    logic        chk;
    logic [31:0] expR;
  } vec_t;

  logic clk;
  logic NReset;
  int   nTests;
  int   nFail;

  logic [31:0] sbQ[$];
  vec_t        vecs[$];

  dmem_mmio_if bus ();

  dmem_mmio #(.RAM_AW(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .NReset (NReset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample after settle, update the FIFO scoreboard.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
    int   sizeBefore;
    logic popNow;
    @(negedge clk);
    bus.addr      = a;
    bus.wdata     = d;
    bus.we        = w;
    bus.out_ready = r;
    #1;
    sizeBefore = sbQ.size();
    popNow     = r && (sizeBefore != 0);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, sizeBefore != 0});
    if (bus.out_valid && r) begin
      if (sbQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL pop_unexpected: got %h expected no data", bus.out_data);
      end else begin
        chk("out_data", bus.out_data, sbQ.pop_front());
      end
    end
    if (w && a == A_OUT && !(sizeBefore == DEPTH && !popNow)) sbQ.push_back(d);
  endtask

  initial begin
    nTests        = 0;
    nFail         = 0;
    NReset        = 1'b0;
    bus.addr      = A_CYCLE;
    bus.wdata     = 32'd0;
    bus.we        = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_cycle", bus.rdata, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    bus.addr = A_STATUS;
    #1;
    chk("rst_status", bus.rdata, 32'h2);

    // Cycle counter after release, then load and wrap
    @(negedge clk);
    NReset = 1'b1;
    step(A_CYCLE, 0, 1'b0, 1'b0);
    chk("cycle_1", bus.rdata, 32'd1);
    for (int i = 0; i < 4; i++) step(A_CYCLE, 0, 1'b0, 1'b0);
    chk("cycle_5", bus.rdata, 32'd5);
    step(A_CYCLE, 32'hFFFF_FFFE, 1'b1, 1'b0);
    step(A_CYCLE, 0, 1'b0, 1'b0);
    chk("cycle_ld", bus.rdata, 32'hFFFF_FFFE);
    step(A_CYCLE, 0, 1'b0, 1'b0);
    chk("cycle_max", bus.rdata, 32'hFFFF_FFFF);
    step(A_CYCLE, 0, 1'b0, 1'b0);
    chk("cycle_wrap", bus.rdata, 32'd0);

    // Vector table: RAM, FIFO fill/overflow/drain, full push+pop, decode holes
    vecs.push_back('{"ram_wr1",   32'h10, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"ram_old",   32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h1111_1111});
    vecs.push_back('{"ram_rd",    32'h10, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{"ram_wr2",   32'h14, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0});
    vecs.push_back('{"ram_rd2",   32'h14, 32'h0,         1'b0, 1'b0, 1'b1, 32'hCAFE_F00D});
    vecs.push_back('{"ram_rd1",   32'h10, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{"st_empty",  A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2});
    vecs.push_back('{"push1",     A_OUT, 32'd1, 1'b1, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{"push2",     A_OUT, 32'd2, 1'b1, 1'b0, 1'b1, 32'd1});
    vecs.push_back('{"push3",     A_OUT, 32'd3, 1'b1, 1'b0, 1'b1, 32'd2});
    vecs.push_back('{"push4",     A_OUT, 32'd4, 1'b1, 1'b0, 1'b1, 32'd3});
    vecs.push_back('{"st_full",   A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1});
    vecs.push_back('{"cnt_full",  A_OUT, 32'h0, 1'b0, 1'b0, 1'b1, 32'd4});
    vecs.push_back('{"push5_ovf", A_OUT, 32'd5, 1'b1, 1'b0, 1'b1, 32'd4});
    vecs.push_back('{"st_ovf",    A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h5});
    vecs.push_back('{"drain1",    A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h5});
    vecs.push_back('{"drain2",    A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4});
    vecs.push_back('{"drain3",    A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4});
    vecs.push_back('{"drain4",    A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h4});
    vecs.push_back('{"st_drained",A_STATUS, 32'h0, 1'b0, 1'b1, 1'b1, 32'h6});
    vecs.push_back('{"st_keep",   A_STATUS, 32'h3, 1'b1, 1'b0, 1'b1, 32'h6});
    vecs.push_back('{"st_keep2",  A_STATUS, 32'h4, 1'b1, 1'b0, 1'b1, 32'h6});
    vecs.push_back('{"st_clr",    A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2});
    vecs.push_back('{"refill1",   A_OUT, 32'd1, 1'b1, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{"refill2",   A_OUT, 32'd2, 1'b1, 1'b0, 1'b1, 32'd1});
    vecs.push_back('{"refill3",   A_OUT, 32'd3, 1'b1, 1'b0, 1'b1, 32'd2});
    vecs.push_back('{"refill4",   A_OUT, 32'd4, 1'b1, 1'b0, 1'b1, 32'd3});
    vecs.push_back('{"push9_pop", A_OUT, 32'd9, 1'b1, 1'b1, 1'b1, 32'd4});
    vecs.push_back('{"cnt_keep",  A_OUT, 32'h0, 1'b0, 1'b0, 1'b1, 32'd4});
    vecs.push_back('{"st_noovf",  A_STATUS, 32'h0, 1'b0, 1'b0, 1'b1, 32'h1});
    vecs.push_back('{"dr_cnt4",   A_OUT, 32'h0, 1'b0, 1'b1, 1'b1, 32'd4});
    vecs.push_back('{"dr_cnt3",   A_OUT, 32'h0, 1'b0, 1'b1, 1'b1, 32'd3});
    vecs.push_back('{"dr_cnt2",   A_OUT, 32'h0, 1'b0, 1'b1, 1'b1, 32'd2});
    vecs.push_back('{"dr_cnt1",   A_OUT, 32'h0, 1'b0, 1'b1, 1'b1, 32'd1});
    vecs.push_back('{"cnt_zero",  A_OUT, 32'h0, 1'b0, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{"err_clean", 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{"unmap_rd",  32'h8000_000C, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{"alias_wr",  32'h0000_0410, 32'h55, 1'b1, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{"alias_chk", 32'h10, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{"unmap_wr",  32'h8000_0010, 32'h77, 1'b1, 1'b0, 1'b1, 32'h0});
    vecs.push_back('{"unmap_rd2", 32'h8000_0010, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0});

    foreach (vecs[i]) begin
      step(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rdy);
      if (vecs[i].name == "err_clean") chk("err_before", {31'd0, bus.err}, 32'd0);
      if (vecs[i].chk) chk(vecs[i].name, bus.rdata, vecs[i].expR);
    end
    step(32'h0, 0, 1'b0, 1'b0);
    chk("err_after_unmap", {31'd0, bus.err}, {31'd0, EXP_ERR});

    // Asynchronous reset in the middle of a drain
    step(A_OUT, 32'hA1, 1'b1, 1'b0);
    step(A_OUT, 32'hA2, 1'b1, 1'b0);
    step(A_OUT, 32'hA3, 1'b1, 1'b0);
    step(A_CYCLE, 0, 1'b0, 1'b1);
    #2;
    NReset = 1'b0;
    #1;
    sbQ.delete();
    chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_data", bus.out_data, 32'd0);
    chk("arst_cycle", bus.rdata, 32'd0);
    chk("arst_err", {31'd0, bus.err}, 32'd0);
    bus.addr = A_STATUS;
    #1;
    chk("arst_status", bus.rdata, 32'h2);
    @(negedge clk);
    NReset = 1'b1;
    step(32'h10, 0, 1'b0, 1'b0);
    chk("ram_keep1", bus.rdata, 32'hDEAD_BEEF);
    step(32'h14, 0, 1'b0, 1'b0);
    chk("ram_keep2", bus.rdata, 32'hCAFE_F00D);
    chk("err_post_rst", {31'd0, bus.err}, 32'd0);

    // Out-of-range load below the MMIO window
    step(32'h4000_0000, 0, 1'b0, 1'b0);
    chk("hole_rd", bus.rdata, 32'd0);
    chk("err_pre_edge", {31'd0, bus.err}, 32'd0);
    step(32'h0, 0, 1'b0, 1'b0);
    chk("err_set", {31'd0, bus.err}, {31'd0, EXP_ERR});
    for (int i = 0; i < 3; i++) step(32'h10, 0, 1'b0, 1'b0);
    chk("err_hold", {31'd0, bus.err}, {31'd0, EXP_ERR});

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
